// File: rtl/intersection_model.sv
// Environment model for the two-street light controller: per-street car queues
// driven by arrival pulses, traffic sensors, and a sticky light-protocol checker.
module intersection_model #(
  parameter int MAX_Q      = 7,
  parameter int Q_W        = 3,
  parameter int MAX_YELLOW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     la,
  input  logic [1:0]     lb,
  input  logic           arrive_a,
  input  logic           arrive_b,
  output logic           ta,
  output logic           tb,
  output logic [Q_W-1:0] qa,
  output logic [Q_W-1:0] qb,
  output logic           depart_a,
  output logic           depart_b,
  output logic           err_code,
  output logic           err_seq,
  output logic           err_conflict,
  output logic           err_yellow,
  output logic           overflow
);

  localparam logic [1:0] GREEN   = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] RED     = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  localparam int YC_W = $clog2(MAX_YELLOW + 2);
  localparam logic [Q_W-1:0]  MAX_Q_C  = Q_W'(MAX_Q);
  localparam logic [YC_W-1:0] YMAX_C   = YC_W'(MAX_YELLOW);
  localparam logic [YC_W-1:0] YSAT_C   = YC_W'(MAX_YELLOW + 1);

  // Direct colour skips; anything involving the illegal code is left to err_code.
  function automatic logic bad_step(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      {GREEN, RED}:    bad_step = 1'b1;
      {YELLOW, GREEN}: bad_step = 1'b1;
      {RED, YELLOW}:   bad_step = 1'b1;
      default:         bad_step = 1'b0;
    endcase
  endfunction

  function automatic logic [YC_W-1:0] yel_next(input logic [1:0] light, input logic [YC_W-1:0] cnt);
    if (light != YELLOW) begin
      yel_next = '0;
    end else if (cnt == YSAT_C) begin
      yel_next = cnt;
    end else begin
      yel_next = cnt + YC_W'(1);
    end
  endfunction

  logic [Q_W-1:0]  qa_q, qa_d, qb_q, qb_d;
  logic [YC_W-1:0] ya_q, ya_d, yb_q, yb_d;
  logic [1:0]      prev_la_q, prev_lb_q;
  logic            primed_q;
  logic            depart_a_q, depart_b_q;
  logic            err_code_q, err_code_d;
  logic            err_seq_q, err_seq_d;
  logic            err_conflict_q, err_conflict_d;
  logic            err_yellow_q, err_yellow_d;
  logic            overflow_q, overflow_d;
  logic            dep_a, dep_b, acc_a, acc_b;

  always_comb begin
    dep_a = (la == GREEN) && (qa_q != '0);
    dep_b = (lb == GREEN) && (qb_q != '0);
    // A departure in the same cycle frees the slot for an arrival into a full queue.
    acc_a = arrive_a && ((qa_q < MAX_Q_C) || dep_a);
    acc_b = arrive_b && ((qb_q < MAX_Q_C) || dep_b);
    qa_d  = qa_q + Q_W'(acc_a) - Q_W'(dep_a);
    qb_d  = qb_q + Q_W'(acc_b) - Q_W'(dep_b);

    ya_d  = yel_next(la, ya_q);
    yb_d  = yel_next(lb, yb_q);

    err_code_d     = err_code_q | (la == ILLEGAL) | (lb == ILLEGAL);
    err_seq_d      = err_seq_q | (primed_q & (bad_step(prev_la_q, la) | bad_step(prev_lb_q, lb)));
    err_conflict_d = err_conflict_q | ((la != RED) && (lb != RED));
    err_yellow_d   = err_yellow_q | ((la == YELLOW) && (ya_q == YMAX_C))
                                  | ((lb == YELLOW) && (yb_q == YMAX_C));
    overflow_d     = overflow_q | (arrive_a & ~acc_a) | (arrive_b & ~acc_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qa_q           <= '0;
      qb_q           <= '0;
      ya_q           <= '0;
      yb_q           <= '0;
      prev_la_q      <= RED;
      prev_lb_q      <= RED;
      primed_q       <= 1'b0;
      depart_a_q     <= 1'b0;
      depart_b_q     <= 1'b0;
      err_code_q     <= 1'b0;
      err_seq_q      <= 1'b0;
      err_conflict_q <= 1'b0;
      err_yellow_q   <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      qa_q           <= qa_d;
      qb_q           <= qb_d;
      ya_q           <= ya_d;
      yb_q           <= yb_d;
      prev_la_q      <= la;
      prev_lb_q      <= lb;
      primed_q       <= 1'b1;
      depart_a_q     <= dep_a;
      depart_b_q     <= dep_b;
      err_code_q     <= err_code_d;
      err_seq_q      <= err_seq_d;
      err_conflict_q <= err_conflict_d;
      err_yellow_q   <= err_yellow_d;
      overflow_q     <= overflow_d;
    end
  end

  assign qa           = qa_q;
  assign qb           = qb_q;
  assign ta           = |qa_q;
  assign tb           = |qb_q;
  assign depart_a     = depart_a_q;
  assign depart_b     = depart_b_q;
  assign err_code     = err_code_q;
  assign err_seq      = err_seq_q;
  assign err_conflict = err_conflict_q;
  assign err_yellow   = err_yellow_q;
  assign overflow     = overflow_q;

endmodule
